// File: rtl/ram_pattern_seq.sv
// ram_pattern_seq
//   Fills an inferred single-port RAM with a seed-derived pattern on start,
//   then reads it back cyclically, one word every RD_DIV clocks. A key pulse
//   toggles pause/resume of the readback.
// Ports:
//   sys_clk, rst       clock, asynchronous active-high reset
//   start              latch pattern/seed and (re)start the fill
//   key_flag           pause/resume toggle while reading
//   pattern, seed      fill pattern select and seed, sampled with start
//   q, q_valid         last word read and its one-cycle update strobe
//   rd_addr            address of the word on q
//   busy, fill_done    fill in progress / last fill write this cycle
//   state              0 IDLE, 1 FILL, 2 READ, 3 PAUSE
module ram_pattern_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_DIV = 50_000_000
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              key_flag,
  input  logic [1:0]        pattern,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              fill_done,
  output logic [1:0]        state
);

  localparam int DIV_W = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READ  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        pat_q, pat_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [DATA_W-1:0] q_q;
  logic              q_valid_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic              we, re;
  logic [DATA_W-1:0] wdata, addr_ext;
  logic [ADDR_W-1:0] addr_inc;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    div_d    = div_q;
    pat_d    = pat_q;
    seed_d   = seed_q;
    we       = 1'b0;
    re       = 1'b0;
    addr_ext = DATA_W'(addr_q);
    addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

    case (pat_q)
      2'd0:    wdata = addr_ext + seed_q;
      2'd1:    wdata = seed_q - addr_ext;
      2'd2:    wdata = seed_q;
      default: wdata = addr_ext ^ seed_q;
    endcase

    // start outranks key_flag everywhere except during the fill itself
    if (start && state_q != S_FILL) begin
      state_d = S_FILL;
      addr_d  = '0;
      pat_d   = pattern;
      seed_d  = seed;
    end else begin
      case (state_q)
        S_FILL: begin
          we = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = S_READ;
            addr_d  = '0;
            div_d   = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        S_READ: begin
          // divider keeps counting in the cycle that pauses, so a resume
          // lands back on the same phase it left
          re    = (div_q == '0);
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
          if (re) addr_d = addr_inc;
          if (key_flag) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (key_flag) state_d = S_READ;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      div_q     <= '0;
      pat_q     <= '0;
      seed_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      div_q     <= div_d;
      pat_q     <= pat_d;
      seed_q    <= seed_d;
      q_valid_q <= re;
      if (re) begin
        q_q       <= mem[addr_q];
        rd_addr_q <= addr_q;
      end
    end
  end

  // RAM array is deliberately outside the reset domain
  always_ff @(posedge sys_clk) begin
    if (we) mem[addr_q] <= wdata;
  end

  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = (state_q == S_FILL);
  assign fill_done = (state_q == S_FILL) && (addr_q == LAST_ADDR);
  assign state     = state_q;

endmodule

// File: tb/tb_ram_pattern_seq.sv
// Directed bench for ram_pattern_seq: DEPTH=16, RD_DIV=4 main instance plus
// an RD_DIV=1 instance for the continuous-read case.
module tb_ram_pattern_seq;

  logic       clk;
  logic       rst, start, key_flag;
  logic [1:0] pattern;
  logic [7:0] seed;
  logic [7:0] q;
  logic       q_valid, busy, fill_done;
  logic [3:0] rd_addr;
  logic [1:0] state;

  logic       start2, key2;
  logic [1:0] pattern2;
  logic [7:0] seed2;
  logic [7:0] q2;
  logic       q_valid2, busy2, fill_done2;
  logic [3:0] rd_addr2;
  logic [1:0] state2;

  int checks, errors;

  ram_pattern_seq #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_DIV(4)) dut (
    .sys_clk(clk), .rst(rst), .start(start), .key_flag(key_flag),
    .pattern(pattern), .seed(seed), .q(q), .q_valid(q_valid),
    .rd_addr(rd_addr), .busy(busy), .fill_done(fill_done), .state(state)
  );

  ram_pattern_seq #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_DIV(1)) dut2 (
    .sys_clk(clk), .rst(rst), .start(start2), .key_flag(key2),
    .pattern(pattern2), .seed(seed2), .q(q2), .q_valid(q_valid2),
    .rd_addr(rd_addr2), .busy(busy2), .fill_done(fill_done2), .state(state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_word(input logic [1:0] p, input logic [7:0] s,
                                          input logic [7:0] a);
    case (p)
      2'd0:    return a + s;
      2'd1:    return s - a;
      2'd2:    return s;
      default: return a ^ s;
    endcase
  endfunction

  // ticks until the next q_valid, bounded
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!q_valid && n < 20);
    if (!q_valid) chk("vld_timeout", {31'd0, q_valid}, 32'd1);
  endtask

  task automatic do_fill(input logic [1:0] p, input logic [7:0] s, input logic k);
    start = 1'b1; pattern = p; seed = s; key_flag = k;
    tick();
    start = 1'b0; key_flag = 1'b0;
    chk("fill_enter", {30'd0, state}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("busy", {31'd0, busy}, 32'd1);
      chk("fill_done", {31'd0, fill_done}, (i == 15) ? 32'd1 : 32'd0);
      tick();
    end
    chk("read_enter", {30'd0, state}, 32'd2);
    chk("busy_low", {31'd0, busy}, 32'd0);
  endtask

  task automatic read_chk(input logic [1:0] p, input logic [7:0] s, input int n);
    int g;
    logic [7:0] a;
    for (int k = 0; k < n; k++) begin
      wait_valid(g);
      a = 8'(k % 16);
      chk("gap", g, (k == 0) ? 32'd1 : 32'd4);
      chk("q", {24'd0, q}, {24'd0, exp_word(p, s, a)});
      chk("rd_addr", {28'd0, rd_addr}, {24'd0, a});
    end
  endtask

  initial begin
    logic [7:0] frozen;
    logic [3:0] last_addr;
    int g;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; key_flag = 1'b0; pattern = 2'd0; seed = 8'd0;
    start2 = 1'b0; key2 = 1'b0; pattern2 = 2'd0; seed2 = 8'd0;
    tick(); tick();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_qv", {31'd0, q_valid}, 32'd0);
    chk("rst_addr", {28'd0, rd_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();
    // key ignored in IDLE
    key_flag = 1'b1; tick(); key_flag = 1'b0;
    chk("idle_key", {30'd0, state}, 32'd0);

    // pattern 0, seed 10: 17 reads to see the wrap
    do_fill(2'd0, 8'h10, 1'b0);
    read_chk(2'd0, 8'h10, 17);

    // pattern 1, seed 05: wraps below zero
    do_fill(2'd1, 8'h05, 1'b0);
    chk("q_hold_fill", {24'd0, q}, 32'h10);
    read_chk(2'd1, 8'h05, 16);

    // pause 2 cycles after the last q_valid (rd_addr 15)
    last_addr = rd_addr;
    tick(); tick();
    key_flag = 1'b1; tick(); key_flag = 1'b0;
    chk("pause_state", {30'd0, state}, 32'd3);
    frozen = q;
    for (int i = 0; i < 20; i++) begin
      chk("pause_qv", {31'd0, q_valid}, 32'd0);
      chk("pause_q", {24'd0, q}, {24'd0, frozen});
      tick();
    end
    key_flag = 1'b1; tick(); key_flag = 1'b0;
    chk("resume_state", {30'd0, state}, 32'd2);
    chk("resume_qv0", {31'd0, q_valid}, 32'd0);
    tick();
    chk("resume_qv", {31'd0, q_valid}, 32'd1);
    chk("resume_addr", {28'd0, rd_addr}, {28'd0, last_addr + 4'd1});
    chk("resume_q", {24'd0, q}, 32'h05);

    // start + key together: start wins
    do_fill(2'd2, 8'hA5, 1'b1);
    read_chk(2'd2, 8'hA5, 16);

    // reset on the 7th FILL cycle
    start = 1'b1; pattern = 2'd0; seed = 8'h77;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("fill7_addr_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_q", {24'd0, q}, 32'd0);
    chk("arst_addr", {28'd0, rd_addr}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, fill_done}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("post_rst_done", {31'd0, fill_done}, 32'd0);
      chk("post_rst_state", {30'd0, state}, 32'd0);
      tick();
    end
    do_fill(2'd3, 8'h0F, 1'b0);
    read_chk(2'd3, 8'h0F, 16);

    // RD_DIV=1 instance: continuous reads
    start2 = 1'b1; pattern2 = 2'd0; seed2 = 8'h00;
    tick();
    start2 = 1'b0;
    repeat (16) tick();
    chk("d1_read", {30'd0, state2}, 32'd2);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("d1_qv", {31'd0, q_valid2}, 32'd1);
      chk("d1_q", {24'd0, q2}, k % 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
